// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Results land in HI/LO on the edge where busy falls; out is the mfhi/mflo read path.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;

    logic [2*DW-1:0] a_ext, b_ext, prod;
    logic            is_mul, mul_signed, div_signed;
    logic            a_neg, b_neg;
    logic [DW-1:0]   a_mag, b_mag, den, q_mag, r_mag, quot, rem;

    // Result datapath works only on the captured operands.
    always_comb begin
        is_mul     = (op_q == OP_MULT) || (op_q == OP_MULTU);
        mul_signed = (op_q == OP_MULT);
        div_signed = (op_q == OP_DIV);

        a_ext = mul_signed ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
        b_ext = mul_signed ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
        prod  = a_ext * b_ext;

        // Magnitude division; 0x80000000 / -1 wraps back to 0x80000000 through the negate.
        a_neg = div_signed & a_q[DW-1];
        b_neg = div_signed & b_q[DW-1];
        a_mag = a_neg ? (~a_q + DW'(1)) : a_q;
        b_mag = b_neg ? (~b_q + DW'(1)) : b_q;
        den   = (b_q == '0) ? DW'(1) : b_mag;
        q_mag = a_mag / den;
        r_mag = a_mag % den;
        quot  = (a_neg ^ b_neg) ? (~q_mag + DW'(1)) : q_mag;
        rem   = a_neg ? (~r_mag + DW'(1)) : r_mag;
    end

    // Next-state logic: capture on start when idle, count down while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            op_d    = op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (is_mul) begin
                        hi_d = prod[2*DW-1:DW];
                        lo_d = prod[DW-1:0];
                    end else if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q == S_BUSY);
    assign stall = busy | (start & (op >= OP_MULT) & (op <= OP_MTLO));
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign out   = (op == OP_MFLO) ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: vector table through a scoreboard queue, plus hand-written
// sequences for busy-time start, mid-operation reset and MTLO->MFLO forwarding.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy, stall;
    logic [31:0] HI, LO, out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[16];
    vec_t sb_q[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .stall(stall), .HI(HI), .LO(LO), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one op for a single cycle, then wait (bounded) for busy to fall and score it.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t exp;
        int   cycles;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        A     = v.a;
        B     = v.b;
        sb_q.push_back(v);
        #1;
        check($sformatf("v%0d_stall", idx), 32'(stall), 32'((v.op >= 4'd1) && (v.op <= 4'd8)));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
        A     = $urandom;
        B     = $urandom;
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        exp = sb_q.pop_front();
        check($sformatf("v%0d_cycles", idx), 32'(cycles), 32'(exp.cycles));
        check($sformatf("v%0d_hi", idx), HI, exp.hi);
        check($sformatf("v%0d_lo", idx), LO, exp.lo);
    endtask

    initial begin
        vecs[0]  = '{4'd1,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{4'd3,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{4'd4,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{4'd7,  32'h12345678, 32'h00000000, 32'h12345678, 32'h00000003, 0};
        vecs[5]  = '{4'd3,  32'h00000005, 32'h00000000, 32'h12345678, 32'h00000003, 10};
        vecs[6]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[7]  = '{4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[8]  = '{4'd3,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{4'd3,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
        vecs[10] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[11] = '{4'd8,  32'h00000055, 32'h00000000, 32'hFFFFFFFE, 32'h00000055, 0};
        vecs[12] = '{4'd4,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[13] = '{4'd0,  32'hAAAAAAAA, 32'h00000003, 32'h0000000F, 32'h0FFFFFFF, 0};
        vecs[14] = '{4'd12, 32'hAAAAAAAA, 32'h00000003, 32'h0000000F, 32'h0FFFFFFF, 0};
        vecs[15] = '{4'd2,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

        reset = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Start issued during busy must be ignored while stall stays high.
        @(negedge clk);
        start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("s032_stall_c%0d", k), 32'(stall), 32'd1);
            if (k == 2) begin
                start = 1'b1; op = 4'd8; A = 32'hDEADBEEF;
            end else begin
                start = 1'b0; op = 4'd0;
            end
        end
        @(negedge clk);
        check("s032_busy", 32'(busy), 32'd0);
        check("s032_hi", HI, 32'd0);
        check("s032_lo", LO, 32'd12);
        repeat (3) @(negedge clk);
        check("s032_lo_hold", LO, 32'd12);

        // Reset in the middle of a divide aborts it.
        run_vec('{4'd7, 32'h00000077, 32'h0, 32'h00000077, 32'd12, 0}, 100);
        @(negedge clk);
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("s033_busy", 32'(busy), 32'd0);
        check("s033_hi", HI, 32'd0);
        check("s033_lo", LO, 32'd0);
        repeat (15) @(negedge clk);
        check("s033_busy_late", 32'(busy), 32'd0);
        check("s033_hi_late", HI, 32'd0);
        check("s033_lo_late", LO, 32'd0);

        // MTLO immediately followed by MFLO sees the new value.
        @(negedge clk);
        start = 1'b1; op = 4'd8; A = 32'h00000055;
        @(posedge clk);
        #1;
        op = 4'd6; A = 32'h0;
        #1;
        check("s034_out_mflo", out, 32'h00000055);
        check("s034_stall", 32'(stall), 32'd1);
        op = 4'd5;
        #1;
        check("s034_out_mfhi", out, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        check("s034_hi", HI, 32'd0);
        check("s034_lo", LO, 32'h00000055);
        check("s034_busy", 32'(busy), 32'd0);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
